// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, addresses the combinational ROM, picks the next PC.
// Latency: instruction appears on Instruction the same cycle its PC is on InstrAddr (no delay slot).
// Backpressure: none; PC advances every RUN cycle, decoder Ack halts the run.
module fetch_unit #(
    parameter int PC_W       = 10,
    parameter int INSTR_W    = 9,
    parameter int START_ADDR = 0,
    parameter int CNT_W      = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [INSTR_W-1:0] InstrIn,
    output logic [PC_W-1:0]    InstrAddr,
    output logic [INSTR_W-1:0] Instruction,
    output logic               Running,
    input  logic               Jump,
    input  logic               BranchEn,
    input  logic [1:0]         TargSel,
    input  logic               Ack,
    input  logic               LutWrEn,
    input  logic [1:0]         LutWrAddr,
    input  logic [PC_W-1:0]    LutWrData,
    output logic               Done,
    output logic [CNT_W-1:0]   CycleCount
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    state_t            r_state;
    logic [PC_W-1:0]   r_pc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_running;
    logic              r_done;
    logic [PC_W-1:0]   r_lut [4];

    logic              w_cnt_sat;
    logic              w_taken;
    logic [PC_W-1:0]   w_target;

    // Offsets are stored at full PC width, so the PC-width add already is the
    // sign-extended add modulo 2^PC_W; wrap-around falls out naturally.
    assign w_cnt_sat = &r_cnt;
    assign w_taken   = BranchEn & Jump;
    assign w_target  = r_pc + r_lut[TargSel];

    assign InstrAddr   = r_pc;
    assign Instruction = r_running ? InstrIn : '0;
    assign Running     = r_running;
    assign Done        = r_done;
    assign CycleCount  = r_cnt;

    // Target LUT: writable only while not running; a write alongside Start is
    // visible to the very first branch of the new run.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 4; i++) begin
                r_lut[i] <= '0;
            end
        end else if (LutWrEn && (r_state != S_RUN)) begin
            r_lut[LutWrAddr] <= LutWrData;
        end
    end

    // Run FSM with PC selection, cycle counter and registered status decodes.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_pc      <= START_PC;
            r_cnt     <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (Start) begin
                        r_state   <= S_RUN;
                        r_pc      <= START_PC;
                        r_cnt     <= '0;
                        r_running <= 1'b1;
                        r_done    <= 1'b0;
                    end
                end
                S_RUN: begin
                    // The halting cycle is still a RUN cycle and is counted.
                    if (!w_cnt_sat) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (Ack) begin
                        // PC stays on the Ack instruction for post-mortem.
                        r_state   <= S_HALT;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                    end else if (w_taken) begin
                        r_pc <= w_target;
                    end else begin
                        r_pc <= r_pc + 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_running <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: ROM model, decoder Ack on opcode 9'h1FF, hand-computed PCs.
// Checks are taken 1 time unit after each rising edge.
// Jump/BranchEn/TargSel are driven directly by the stimulus sequence.
module tb_fetch_unit;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [8:0]  InstrIn;
    logic [9:0]  InstrAddr;
    logic [8:0]  Instruction;
    logic        Running;
    logic        Jump;
    logic        BranchEn;
    logic [1:0]  TargSel;
    logic        Ack;
    logic        LutWrEn;
    logic [1:0]  LutWrAddr;
    logic [9:0]  LutWrData;
    logic        Done;
    logic [15:0] CycleCount;

    logic [8:0]  rom [0:1023];

    int total = 0;
    int bad   = 0;

    fetch_unit #(
        .PC_W(10), .INSTR_W(9), .START_ADDR(0), .CNT_W(16)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .InstrIn(InstrIn),
        .InstrAddr(InstrAddr), .Instruction(Instruction), .Running(Running),
        .Jump(Jump), .BranchEn(BranchEn), .TargSel(TargSel), .Ack(Ack),
        .LutWrEn(LutWrEn), .LutWrAddr(LutWrAddr), .LutWrData(LutWrData),
        .Done(Done), .CycleCount(CycleCount)
    );

    // Combinational instruction ROM and a minimal decoder producing Ack.
    assign InstrIn = rom[InstrAddr];
    assign Ack     = (Instruction == 9'h1FF);

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
        rom[0] = 9'h011;   // ADD
        rom[1] = 9'h022;   // OR
        rom[2] = 9'h044;   // AND
        rom[3] = 9'h1FF;   // program done
        Reset = 1'b1; Start = 1'b0; Jump = 1'b0; BranchEn = 1'b0; TargSel = 2'd0;
        LutWrEn = 1'b0; LutWrAddr = 2'd0; LutWrData = 10'd0;

        // Reset state
        #2;
        chk("rst_addr",  InstrAddr,   0);
        chk("rst_run",   Running,     0);
        chk("rst_done",  Done,        0);
        chk("rst_cnt",   CycleCount,  0);
        chk("rst_instr", Instruction, 0);
        #5 Reset = 1'b0;

        // Straight-line program 0..3, halting on the 1FF at addr 3
        tick();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("p1_run",   Running,     1);
        chk("p1_a0",    InstrAddr,   0);
        chk("p1_i0",    Instruction, 9'h011);
        tick(); chk("p1_a1", InstrAddr, 1);
        tick(); chk("p1_a2", InstrAddr, 2);
        tick(); chk("p1_a3", InstrAddr, 3);
        chk("p1_ack_cnt", CycleCount, 3);
        tick();
        chk("p1_done",  Done,        1);
        chk("p1_run0",  Running,     0);
        chk("p1_pc",    InstrAddr,   3);
        chk("p1_cnt",   CycleCount,  4);
        chk("p1_instr", Instruction, 0);
        tick();
        chk("p1_hold_cnt", CycleCount, 4);
        chk("p1_hold_pc",  InstrAddr,  3);

        // LUT[2] = +5 written in IDLE, taken branch at addr 4 -> 9
        #2 Reset = 1'b1;
        #1 Reset = 1'b0;
        rom[3] = 9'h000;
        rom[11] = 9'h1FF;
        LutWrEn = 1'b1; LutWrAddr = 2'd2; LutWrData = 10'd5;
        tick();
        LutWrEn = 1'b0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick(); tick(); tick(); tick();
        chk("br_a4", InstrAddr, 4);
        Jump = 1'b1; BranchEn = 1'b1; TargSel = 2'd2;
        tick();
        chk("br_taken", InstrAddr, 9);
        // Branch present but condition false -> sequential
        Jump = 1'b0;
        tick();
        chk("br_not_taken", InstrAddr, 10);
        chk("br_cnt", CycleCount, 6);
        BranchEn = 1'b0;
        tick();
        chk("br_a11", InstrAddr, 11);
        tick();
        chk("br_done", Done, 1);
        chk("br_pc",   InstrAddr, 11);
        chk("br_halt_cnt", CycleCount, 8);

        // In HALT: write LUT[1] = -3 together with Start
        LutWrEn = 1'b1; LutWrAddr = 2'd1; LutWrData = 10'h3FD; Start = 1'b1;
        tick();
        LutWrEn = 1'b0; Start = 1'b0;
        chk("rs_done0", Done, 0);
        chk("rs_run",   Running, 1);
        chk("rs_pc",    InstrAddr, 0);
        chk("rs_cnt",   CycleCount, 0);
        tick();
        chk("neg_a1", InstrAddr, 1);
        Jump = 1'b1; BranchEn = 1'b1; TargSel = 2'd1;
        tick();
        chk("neg_wrap", InstrAddr, 10'd1022);
        Jump = 1'b0; BranchEn = 1'b0;
        // LUT write during RUN must be dropped
        LutWrEn = 1'b1; LutWrAddr = 2'd0; LutWrData = 10'd7;
        tick();
        LutWrEn = 1'b0;
        chk("a1023", InstrAddr, 10'd1023);
        tick();
        chk("inc_wrap", InstrAddr, 0);
        // Taken branch via entry 0 (still 0): self-loop; Start mid-RUN ignored
        Jump = 1'b1; BranchEn = 1'b1; TargSel = 2'd0; Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("selfloop_pc",  InstrAddr, 0);
        chk("midstart_run", Running,   1);
        chk("midstart_cnt", CycleCount, 5);

        // Saturation of the cycle counter on a self-loop
        for (int i = 0; i < 65529; i++) tick();
        chk("sat_fffe", CycleCount, 16'hFFFE);
        tick();
        chk("sat_ffff", CycleCount, 16'hFFFF);
        tick();
        chk("sat_hold", CycleCount, 16'hFFFF);
        chk("sat_pc",   InstrAddr,  0);

        // Asynchronous reset mid-run at PC = 6
        Jump = 1'b0; BranchEn = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("ar_pc6", InstrAddr, 6);
        #2 Reset = 1'b1;
        #1;
        chk("ar_pc",    InstrAddr,   0);
        chk("ar_run",   Running,     0);
        chk("ar_done",  Done,        0);
        chk("ar_cnt",   CycleCount,  0);
        chk("ar_instr", Instruction, 0);
        #1 Reset = 1'b0;

        // LUT cleared by reset: taken branches via entries 1 and 2 self-loop
        Start = 1'b1;
        tick();
        Start = 1'b0;
        Jump = 1'b1; BranchEn = 1'b1; TargSel = 2'd2;
        tick();
        chk("ar_lut2", InstrAddr, 0);
        TargSel = 2'd1;
        tick();
        chk("ar_lut1", InstrAddr, 0);
        Jump = 1'b0; BranchEn = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the control decoder. It holds the program counter, drives the instruction ROM address, and presents the fetched 9-bit instruction to the decoder. It consumes the decoder's Jump/BranchEn/TargSel/Ack outputs to pick the next PC: sequential, branch via a programmable 4-entry relative-offset target LUT, or halt. A Start/Done run FSM and a cycle counter frame each program execution.

Parameters:
PC_W, 10, program counter / ROM address width
INSTR_W, 9, instruction width
START_ADDR, 0, PC value loaded on reset and on every Start
CNT_W, 16, cycle counter width

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Start  in  1  run request; sampled in IDLE or HALT only
InstrIn  in  INSTR_W  instruction ROM read data at InstrAddr (combinational ROM)
InstrAddr  out  PC_W  ROM address, equals PC
Instruction  out  INSTR_W  to decoder; InstrIn while RUN, all-zero otherwise
Running  out  1  high in RUN; downstream gates RegWrEn/MemWrEn with it
Jump  in  1  from decoder: branch condition true
BranchEn  in  1  from decoder: instruction is a branch
TargSel  in  2  from decoder: target LUT index
Ack  in  1  from decoder: program-done instruction
LutWrEn  in  1  target LUT write strobe
LutWrAddr  in  2  LUT entry to write
LutWrData  in  PC_W  signed two's-complement PC offset
Done  out  1  high in HALT
CycleCount  out  CNT_W  RUN cycles of current/last run

Behaviour:
- States: IDLE, RUN, HALT. Reset (async) -> IDLE; PC=START_ADDR, CycleCount=0, all LUT entries=0, Done=0, Running=0.
- Outputs are registered state decodes: Running=(state==RUN), Done=(state==HALT). InstrAddr=PC at all times.
- IDLE: Start=1 -> RUN next edge; PC=START_ADDR, CycleCount=0.
- RUN, evaluated each rising edge, priority order:
  1. Ack=1 -> HALT; PC holds (points at the Ack instruction); CycleCount increments for this cycle.
  2. BranchEn=1 and Jump=1 -> PC <= PC + sign_extend(LUT[TargSel]).
  3. Otherwise -> PC <= PC + 1. This includes BranchEn=1 with Jump=0.
- PC arithmetic is modulo 2^PC_W: 1023+1 wraps to 0; 5 + (-8) wraps to 1021.
- LUT offset 0 makes a taken branch a self-loop. This is legal and needs no detection.
- CycleCount increments by 1 on every edge spent in RUN, including the Ack cycle. It saturates at 2^CNT_W-1. It holds in HALT and IDLE.
- Start in RUN is ignored.
- HALT: Start=1 -> RUN next edge; PC=START_ADDR, CycleCount=0; Done falls on the same edge.
- The ROM is combinational and the PC feeds it directly, so there is no branch delay slot. The instruction after a taken branch is the target instruction.
- LUT write: LutWrEn=1 in IDLE or HALT writes LutWrData to LUT[LutWrAddr] at the edge. Writes in RUN are ignored.
- A LUT write is read by a branch on the cycle after the write edge.
- LutWrEn and Start in the same cycle: the write is performed and the run starts. The written value is visible to the first branch.
- Jump, BranchEn and Ack are ignored outside RUN.
- Reset asserted mid-run returns to IDLE immediately and asynchronously. LUT contents are cleared.

Test Plan:
- Reset, then Start pulse with ROM 0..2 = ADD,OR,AND and addr 3 = 9'h1FF -> InstrAddr 0,1,2,3; HALT entered at the edge after addr 3 is presented; Done=1; PC=3; CycleCount=4.
- Write LUT[2]=+5 in IDLE; program has a taken branch (Jump=1, BranchEn=1, TargSel=2) at addr 4 -> next InstrAddr 9. Repeat with Jump=0 -> next InstrAddr 5.
- LUT[1]=-3 (10'h3FD), taken branch at addr 1 -> InstrAddr wraps to 1022.
- LutWrEn during RUN with data +7 to entry 0 -> entry unchanged; a later taken branch with TargSel=0 uses the old value.
- After HALT, pulse Start -> Done drops next edge; PC=0; CycleCount restarts from 0. A Start asserted mid-RUN changes nothing.
- Assert Reset while PC=6 in RUN -> state IDLE, PC=0, Running=0, LUT entries 0, all without waiting for a clock edge.
- Self-loop for 70000 cycles -> CycleCount saturates at 16'hFFFF.
